// File: rtl/load_store_sequencer.sv
// Load/store sequencer between the pipeline MEM stage and a handshaked data memory.
// Issues one access at a time, aligns stores, extends loads and aborts on memory timeout.
module load_store_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic        ReqByte,
  input  logic        ReqUnsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Stall,
  output logic        MemReq,
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBE,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        RespError
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             is_write, is_write_nx;
  logic             is_byte, is_byte_nx;
  logic             is_unsigned, is_unsigned_nx;
  logic [1:0]       lane, lane_nx;
  logic             ready_nx, stall_nx;
  logic             mem_req_nx, mem_write_nx;
  logic [31:0]      mem_addr_nx, mem_wdata_nx;
  logic [3:0]       mem_be_nx;
  logic             resp_valid_nx, resp_error_nx;
  logic [31:0]      resp_data_nx;

  // Picks the addressed byte lane (little-endian) and extends it, or passes a word through.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] sel,
                                              input logic by, input logic un);
    logic [7:0] b;
    b = rdata[{sel, 3'b000} +: 8];
    if (!by)
      return rdata;
    else if (un)
      return {24'b0, b};
    else
      return {{24{b[7]}}, b};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      is_write    <= 1'b0;
      is_byte     <= 1'b0;
      is_unsigned <= 1'b0;
      lane        <= 2'b00;
      ReqReady    <= 1'b1;
      Stall       <= 1'b0;
      MemReq      <= 1'b0;
      MemWrite    <= 1'b0;
      MemAddr     <= '0;
      MemBE       <= '0;
      MemWData    <= '0;
      RespValid   <= 1'b0;
      RespData    <= '0;
      RespError   <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      is_write    <= is_write_nx;
      is_byte     <= is_byte_nx;
      is_unsigned <= is_unsigned_nx;
      lane        <= lane_nx;
      ReqReady    <= ready_nx;
      Stall       <= stall_nx;
      MemReq      <= mem_req_nx;
      MemWrite    <= mem_write_nx;
      MemAddr     <= mem_addr_nx;
      MemBE       <= mem_be_nx;
      MemWData    <= mem_wdata_nx;
      RespValid   <= resp_valid_nx;
      RespData    <= resp_data_nx;
      RespError   <= resp_error_nx;
    end
  end

  // Every output is computed one cycle ahead here so the ports come straight from flops.
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    is_write_nx    = is_write;
    is_byte_nx     = is_byte;
    is_unsigned_nx = is_unsigned;
    lane_nx        = lane;
    ready_nx       = ReqReady;
    stall_nx       = Stall;
    mem_req_nx     = MemReq;
    mem_write_nx   = MemWrite;
    mem_addr_nx    = MemAddr;
    mem_be_nx      = MemBE;
    mem_wdata_nx   = MemWData;
    resp_valid_nx  = 1'b0;
    resp_data_nx   = RespData;
    resp_error_nx  = RespError;

    case (state)
      IDLE: begin
        if (ReqValid) begin
          is_write_nx    = ReqWrite;
          is_byte_nx     = ReqByte;
          is_unsigned_nx = ReqUnsigned;
          lane_nx        = Addr[1:0];
          ready_nx       = 1'b0;
          stall_nx       = 1'b1;
          // A misaligned word never reaches memory; it is answered with an error directly.
          if (!ReqByte && (Addr[1:0] != 2'b00)) begin
            state_nx      = RESP;
            resp_valid_nx = 1'b1;
            resp_data_nx  = '0;
            resp_error_nx = 1'b1;
          end else begin
            state_nx     = ACCESS;
            cnt_nx       = '0;
            mem_req_nx   = 1'b1;
            mem_write_nx = ReqWrite;
            mem_addr_nx  = {Addr[31:2], 2'b00};
            if (ReqWrite && ReqByte) begin
              mem_be_nx    = 4'b0001 << Addr[1:0];
              mem_wdata_nx = {4{WData[7:0]}};
            end else if (ReqWrite) begin
              mem_be_nx    = 4'hF;
              mem_wdata_nx = WData;
            end else begin
              mem_be_nx    = 4'hF;
              mem_wdata_nx = '0;
            end
          end
        end
      end

      ACCESS: begin
        // An acknowledge in the final timeout cycle still counts as a normal completion.
        if (MemAck) begin
          state_nx      = RESP;
          mem_req_nx    = 1'b0;
          mem_write_nx  = 1'b0;
          resp_valid_nx = 1'b1;
          resp_data_nx  = is_write ? 32'h0 : load_extend(MemRData, lane, is_byte, is_unsigned);
          resp_error_nx = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_nx      = RESP;
          mem_req_nx    = 1'b0;
          mem_write_nx  = 1'b0;
          resp_valid_nx = 1'b1;
          resp_data_nx  = '0;
          resp_error_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      RESP: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
        stall_nx = 1'b0;
      end

      default: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
        stall_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_sequencer.sv
// Self-checking bench for load_store_sequencer: a scoreboard of expected responses is
// filled as requests are issued and drained whenever RespValid pulses.
module tb_load_store_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ReqValid, ReqReady, ReqWrite, ReqByte, ReqUnsigned;
  logic [31:0] Addr, WData;
  logic        Stall, MemReq, MemWrite;
  logic [31:0] MemAddr, MemWData;
  logic [3:0]  MemBE;
  logic        MemAck;
  logic [31:0] MemRData;
  logic        RespValid, RespError;
  logic [31:0] RespData;

  int testsRun = 0;
  int testsFailed = 0;
  logic [32:0] scoreboard[$];

  load_store_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqByte(ReqByte),
    .ReqUnsigned(ReqUnsigned), .Addr(Addr), .WData(WData), .Stall(Stall),
    .MemReq(MemReq), .MemWrite(MemWrite), .MemAddr(MemAddr), .MemBE(MemBE),
    .MemWData(MemWData), .MemAck(MemAck), .MemRData(MemRData),
    .RespValid(RespValid), .RespData(RespData), .RespError(RespError)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && RespValid) begin
      if (scoreboard.size() == 0) begin
        checkOutput("unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic [32:0] exp;
        exp = scoreboard.pop_front();
        checkOutput("resp_data", RespData, exp[31:0]);
        checkOutput("resp_error", {31'b0, RespError}, {31'b0, exp[32]});
      end
    end
  end

  // ackAt: cycle after acceptance in which MemAck is driven (0 = never).
  task automatic applyStimulus(input logic wr, input logic by, input logic un,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int ackAt, input logic [31:0] rdata,
                               input logic [31:0] expData, input logic expErr,
                               input int expReqCycles, input int expRespCycle,
                               input logic busyNoise);
    int cyc, reqCycles, respCycle, waitN;
    logic [3:0]  expBe;
    logic [31:0] expWd;
    waitN = 0;
    while (!ReqReady && waitN < 50) begin
      @(negedge clk);
      waitN++;
    end
    checkOutput("ready_before_req", {31'b0, ReqReady}, 32'd1);
    ReqValid = 1'b1; ReqWrite = wr; ReqByte = by; ReqUnsigned = un;
    Addr = addr; WData = wdata;
    scoreboard.push_back({expErr, expData});
    @(negedge clk);
    ReqValid = busyNoise;
    Addr = addr ^ 32'h0000_0100;
    WData = ~wdata;
    checkOutput("ready_busy", {31'b0, ReqReady}, 32'd0);
    checkOutput("stall_busy", {31'b0, Stall}, 32'd1);
    if (expReqCycles > 0) begin
      expBe = (wr && by) ? (4'b0001 << addr[1:0]) : 4'hF;
      expWd = wr ? (by ? {4{wdata[7:0]}} : wdata) : 32'h0;
      checkOutput("mem_addr", MemAddr, {addr[31:2], 2'b00});
      checkOutput("mem_be", {28'b0, MemBE}, {28'b0, expBe});
      checkOutput("mem_wdata", MemWData, expWd);
      checkOutput("mem_write", {31'b0, MemWrite}, {31'b0, wr});
    end
    cyc = 1; reqCycles = 0; respCycle = 0;
    while (respCycle == 0 && cyc < 60) begin
      if (MemReq) reqCycles++;
      if (RespValid) respCycle = cyc;
      MemAck   = (cyc == ackAt);
      MemRData = (cyc == ackAt) ? rdata : $urandom;
      @(negedge clk);
      cyc++;
    end
    MemAck = 1'b0;
    ReqValid = 1'b0;
    checkOutput("memreq_cycles", reqCycles, expReqCycles);
    checkOutput("resp_cycle", respCycle, expRespCycle);
    checkOutput("resp_pulse_end", {31'b0, RespValid}, 32'd0);
    checkOutput("ready_after", {31'b0, ReqReady}, 32'd1);
    checkOutput("resp_data_hold", RespData, expData);
    checkOutput("resp_error_hold", {31'b0, RespError}, {31'b0, expErr});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqByte = 1'b0; ReqUnsigned = 1'b0;
    Addr = '0; WData = '0; MemAck = 1'b0; MemRData = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {31'b0, ReqReady}, 32'd1);
    checkOutput("rst_stall", {31'b0, Stall}, 32'd0);
    checkOutput("rst_memreq", {31'b0, MemReq}, 32'd0);
    checkOutput("rst_memaddr", MemAddr, 32'd0);
    checkOutput("rst_membe", {28'b0, MemBE}, 32'd0);
    checkOutput("rst_resp", {30'b0, RespValid, RespError}, 32'd0);
    checkOutput("rst_respdata", RespData, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Acknowledge while idle must be ignored.
    MemAck = 1'b1; @(negedge clk); MemAck = 1'b0; @(negedge clk);
    checkOutput("idle_ack_memreq", {31'b0, MemReq}, 32'd0);

    // T1/T2: byte loads, lane 3 unsigned/signed and lane 1 signed positive.
    applyStimulus(0, 1, 1, 32'h0000_1003, 32'h0, 3, 32'h80AA_55CC, 32'h0000_0080, 0, 3, 4, 0);
    applyStimulus(0, 1, 0, 32'h0000_1003, 32'h0, 3, 32'h80AA_55CC, 32'hFFFF_FF80, 0, 3, 4, 0);
    applyStimulus(0, 1, 0, 32'h0000_1001, 32'h0, 1, 32'h0000_7F00, 32'h0000_007F, 0, 1, 2, 0);
    applyStimulus(0, 1, 1, 32'h0000_1002, 32'h0, 2, 32'h11F2_2233, 32'h0000_00F2, 0, 2, 3, 1);
    // T3: byte store, ack in the first MemReq cycle.
    applyStimulus(1, 1, 0, 32'h0000_2002, 32'h1234_56AB, 1, 32'h0, 32'h0, 0, 1, 2, 0);
    applyStimulus(1, 0, 0, 32'h0000_6004, 32'hCAFE_F00D, 2, 32'h0, 32'h0, 0, 2, 3, 1);
    // T4: misaligned word load and store answered without a memory cycle.
    applyStimulus(0, 0, 0, 32'h0000_3001, 32'h0, 0, 32'h0, 32'h0, 1, 0, 1, 0);
    applyStimulus(1, 0, 0, 32'h0000_7002, 32'h5555_AAAA, 0, 32'h0, 32'h0, 1, 0, 1, 0);
    // T5: timeout, then an acknowledge on the last permitted cycle.
    applyStimulus(0, 0, 0, 32'h0000_4000, 32'h0, 0, 32'h0, 32'h0, 1, 16, 17, 0);
    applyStimulus(0, 0, 0, 32'h0000_4000, 32'h0, 16, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 16, 17, 0);

    // T6: reset in the third ACCESS cycle, followed by a stray acknowledge.
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqByte = 1'b0; Addr = 32'h0000_5000;
    @(negedge clk);
    ReqValid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t6_memreq_before", {31'b0, MemReq}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t6_memreq_async", {31'b0, MemReq}, 32'd0);
    checkOutput("t6_ready_async", {31'b0, ReqReady}, 32'd1);
    checkOutput("t6_respvalid", {31'b0, RespValid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    MemAck = 1'b1; MemRData = 32'h1234_5678;
    @(negedge clk);
    MemAck = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t6_memreq_after", {31'b0, MemReq}, 32'd0);
    checkOutput("t6_ready_after", {31'b0, ReqReady}, 32'd1);

    checkOutput("scoreboard_empty", scoreboard.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
